sad_search_ctrl: RTL

//  Drives the 2x2 SAD datapath from the candidate side: holds the current 2x2 original block (a-quad),

---
 rtl/sad_search_ctrl_pkg.sv | 17 +
 rtl/sad_search_ctrl_addr_gen.sv | 71 +++++++
 rtl/sad_search_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sad_search_ctrl_pkg.sv
// Shared types and constants for the 2x2 SAD candidate search controller.
// FSM state encoding, pixel/SAD widths and the "no candidate yet" SAD value.
package sad_search_ctrl_pkg;

    localparam int PIX_W = 8;
    localparam int SAD_W = 10;
    localparam logic [SAD_W-1:0] SAD_INIT = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sad_search_ctrl_addr_gen.sv
// Candidate scan counters: pixel index k within the quad, candidate offset (dx,dy),
// last-candidate flag and the row-major reference-window read address.
module sad_search_ctrl_addr_gen #(
    parameter int SRCH_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              k_inc_i,
    input  logic              adv_i,
    output logic [1:0]        k_o,
    output logic [ADDR_W-1:0] dx_o,
    output logic [ADDR_W-1:0] dy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_cand_o
);

    localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(SRCH_W - 2);
    localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(SRCH_W);

    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] dx_q, dx_d;
    logic [ADDR_W-1:0] dy_q, dy_d;
    logic [ADDR_W-1:0] row;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q  <= '0;
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            k_q  <= k_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    // k wraps 3 -> 0 on its own, so it is already 0 when the next candidate starts.
    always_comb begin
        k_d  = k_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear_i) begin
            k_d  = '0;
            dx_d = '0;
            dy_d = '0;
        end else begin
            if (k_inc_i) begin
                k_d = k_q + 2'd1;
            end
            if (adv_i) begin
                if (dx_q == LAST_OFS) begin
                    dx_d = '0;
                    dy_d = dy_q + 1'b1;
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
        end
    end

    // k[1] selects the lower row of the quad, k[0] the right-hand column.
    assign row         = dy_q + {{(ADDR_W-1){1'b0}}, k_q[1]};
    assign addr_o      = row * ROW_LEN + dx_q + {{(ADDR_W-1){1'b0}}, k_q[0]};
    assign k_o         = k_q;
    assign dx_o        = dx_q;
    assign dy_o        = dy_q;
    assign last_cand_o = (dx_q == LAST_OFS) && (dy_q == LAST_OFS);

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-window 2x2 SAD motion search controller; feeds an external combinational SAD unit.
// Optional macro SAD_EARLY_EXIT_EN: stop the scan at the first candidate with SAD == 0.
module sad_search_ctrl
    import sad_search_ctrl_pkg::*;
#(
    parameter int SRCH_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PIX_W-1:0]  a00,
    input  logic [PIX_W-1:0]  a01,
    input  logic [PIX_W-1:0]  a10,
    input  logic [PIX_W-1:0]  a11,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  oa00,
    output logic [PIX_W-1:0]  oa01,
    output logic [PIX_W-1:0]  oa10,
    output logic [PIX_W-1:0]  oa11,
    output logic [PIX_W-1:0]  ob00,
    output logic [PIX_W-1:0]  ob01,
    output logic [PIX_W-1:0]  ob10,
    output logic [PIX_W-1:0]  ob11,
    output logic              quad_vld,
    input  logic [SAD_W-1:0]  sad,
    output logic              busy,
    output logic              done,
    output logic [SAD_W-1:0]  best_sad,
    output logic [ADDR_W-1:0] best_mvx,
    output logic [ADDR_W-1:0] best_mvy,
    output state_t            dbg_state
);

    // Handshakes: start is a bare pulse honoured only in IDLE (no ready); mem_rd is a
    // fire-and-forget request whose data is valid on mem_data exactly one cycle later.
    state_t state_q, state_d;

    logic [3:0][PIX_W-1:0] oa_q;
    logic [3:0][PIX_W-1:0] ob_q;
    logic [SAD_W-1:0]      best_sad_q;
    logic [ADDR_W-1:0]     best_mvx_q, best_mvy_q;
    logic                  rd_q;
    logic [1:0]            rd_k_q;

    logic [1:0]        k;
    logic [ADDR_W-1:0] dx, dy;
    logic              last_cand;
    logic              accept;
    logic              early_exit;
    logic              ag_adv;

`ifdef SAD_EARLY_EXIT_EN
    assign early_exit = (sad == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && start;
    assign ag_adv = (state_q == ST_EVAL) && !last_cand && !early_exit;

    sad_search_ctrl_addr_gen #(
        .SRCH_W (SRCH_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (accept),
        .k_inc_i     (state_q == ST_FETCH),
        .adv_i       (ag_adv),
        .k_o         (k),
        .dx_o        (dx),
        .dy_o        (dy),
        .addr_o      (mem_addr),
        .last_cand_o (last_cand)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (k == 2'd3) state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_EVAL;
            ST_EVAL:  state_d = (last_cand || early_exit) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            oa_q       <= '0;
            ob_q       <= '0;
            best_sad_q <= SAD_INIT;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
            rd_q       <= 1'b0;
            rd_k_q     <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= mem_rd;
            rd_k_q  <= k;
            // Read k returns one cycle later; the last one lands during WAIT.
            if (rd_q) begin
                ob_q[rd_k_q] <= mem_data;
            end
            if (accept) begin
                oa_q       <= {a11, a10, a01, a00};
                best_sad_q <= SAD_INIT;
                best_mvx_q <= '0;
                best_mvy_q <= '0;
            end else if ((state_q == ST_EVAL) && (sad < best_sad_q)) begin
                best_sad_q <= sad;
                best_mvx_q <= dx;
                best_mvy_q <= dy;
            end
        end
    end

    assign mem_rd    = (state_q == ST_FETCH);
    assign quad_vld  = (state_q == ST_EVAL);
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

    assign oa00 = oa_q[0];
    assign oa01 = oa_q[1];
    assign oa10 = oa_q[2];
    assign oa11 = oa_q[3];
    assign ob00 = ob_q[0];
    assign ob01 = ob_q[1];
    assign ob10 = ob_q[2];
    assign ob11 = ob_q[3];

    assign best_sad = best_sad_q;
    assign best_mvx = best_mvx_q;
    assign best_mvy = best_mvy_q;

endmodule
